// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
// Scans a 4-digit common-anode seven-segment display. One digit is lit per
// slot of REFRESH_DIV cycles. The first BLANK_CYCLES of each slot keep all
// anodes off so that segments can settle without ghosting. Digit values, DP
// requests and the leading-zero enable are latched once per frame, so a frame
// is never drawn from a mix of old and new values.
module ssd_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int DISPLAY_MODE = 9
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic [3:0] i_Digit_1_val,
    input  logic [3:0] i_Digit_2_val,
    input  logic [3:0] i_Digit_3_val,
    input  logic [3:0] i_Digit_4_val,
    input  logic [3:0] i_DP,
    input  logic       i_LZ_EN,
    input  logic       i_EN,
    output logic [3:0] o_AN,
    output logic [6:0] o_SEG,
    output logic       o_DP
);

    localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES);
    localparam logic            DEC_MODE  = (DISPLAY_MODE == 9);

    typedef enum logic {S_BLANK = 1'b0, S_ON = 1'b1} state_t;

    // Active-low segment pattern {g,f,e,d,c,b,a}; decimal mode blanks 10-15.
    function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic dec);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = dec ? 7'h7F : 7'h08;
            4'hB:    s = dec ? 7'h7F : 7'h03;
            4'hC:    s = dec ? 7'h7F : 7'h46;
            4'hD:    s = dec ? 7'h7F : 7'h21;
            4'hE:    s = dec ? 7'h7F : 7'h06;
            4'hF:    s = dec ? 7'h7F : 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    state_t        state_q, state_d;
    logic [3:0]    d1_q, d2_q, d3_q, d4_q, dp_q;
    logic          lz_q;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    logic          wrap_s, capture_s, lit_s, sup_s;
    logic [3:0]    d1_s, d2_s, d3_s, d4_s, dpv_s, cur_s;
    logic          lz_s;

    // Next-state scan position, frame-start bypass of the snapshot, output decode.
    always_comb begin
        wrap_s    = (cnt_q == CNT_MAX);
        cnt_d     = wrap_s ? '0 : cnt_q + CW'(1);
        idx_d     = wrap_s ? idx_q + 2'd1 : idx_q;
        if (wrap_s) begin
            state_d = S_BLANK;
        end else if (cnt_d == BLANK_END) begin
            state_d = S_ON;
        end else begin
            state_d = state_q;
        end

        // At frame start the snapshot is being loaded on this edge; decode from
        // the inputs directly so the first slot already shows the new frame.
        capture_s = (cnt_q == '0) && (idx_q == 2'd0);
        d1_s      = capture_s ? i_Digit_1_val : d1_q;
        d2_s      = capture_s ? i_Digit_2_val : d2_q;
        d3_s      = capture_s ? i_Digit_3_val : d3_q;
        d4_s      = capture_s ? i_Digit_4_val : d4_q;
        dpv_s     = capture_s ? i_DP          : dp_q;
        lz_s      = capture_s ? i_LZ_EN       : lz_q;

        case (idx_q)
            2'd0:    begin cur_s = d1_s; sup_s = 1'b0; end
            2'd1:    begin cur_s = d2_s; sup_s = (d4_s == 4'd0) && (d3_s == 4'd0) && (d2_s == 4'd0); end
            2'd2:    begin cur_s = d3_s; sup_s = (d4_s == 4'd0) && (d3_s == 4'd0); end
            2'd3:    begin cur_s = d4_s; sup_s = (d4_s == 4'd0); end
            default: begin cur_s = 4'd0; sup_s = 1'b0; end
        endcase

        // With no blank phase the slot is lit from its first cycle.
        lit_s = i_EN && ((state_q == S_ON) || (BLANK_CYCLES == 0));

        if (lit_s) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = (lz_s && sup_s) ? 7'h7F : seg_decode(cur_s, DEC_MODE);
            dp_d  = ~dpv_s[idx_q];
        end else begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    // Scan FSM: slot counter, digit index, phase, and the registered display outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= S_BLANK;
            o_AN    <= 4'hF;
            o_SEG   <= 7'h7F;
            o_DP    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            o_AN    <= an_d;
            o_SEG   <= seg_d;
            o_DP    <= dp_d;
        end
    end

    // Frame snapshot of digit values, DP requests and leading-zero enable.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            d1_q <= 4'd0;
            d2_q <= 4'd0;
            d3_q <= 4'd0;
            d4_q <= 4'd0;
            dp_q <= 4'd0;
            lz_q <= 1'b0;
        end else if (capture_s) begin
            d1_q <= i_Digit_1_val;
            d2_q <= i_Digit_2_val;
            d3_q <= i_Digit_3_val;
            d4_q <= i_Digit_4_val;
            dp_q <= i_DP;
            lz_q <= i_LZ_EN;
        end else begin
            d1_q <= d1_q;
            d2_q <= d2_q;
            d3_q <= d3_q;
            d4_q <= d4_q;
            dp_q <= dp_q;
            lz_q <= lz_q;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Testbench for ssd_scan_driver: two instances (hex and decimal mode) share
// stimulus. A behavioural model predicts each edge's outputs into a queue;
// each scenario pops and compares, plus spot checks of fixed values.
module tb_ssd_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d1, d2, d3, d4, dp_in;
    logic       lz, en;
    logic [3:0] an15, an9;
    logic [6:0] seg15, seg9;
    logic       dp15, dp9;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0] sb[$];
    logic [23:0] exp_v, act_v;

    // model state: position within the 32-edge frame and the frame snapshot
    int         m_pos = 0;
    logic [3:0] m_d[4];
    logic [3:0] m_dp;
    logic       m_lz;

    always #5 clk = ~clk;

    ssd_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .DISPLAY_MODE(15)) dut15 (
        .i_CLK(clk), .i_RESET(rst),
        .i_Digit_1_val(d1), .i_Digit_2_val(d2), .i_Digit_3_val(d3), .i_Digit_4_val(d4),
        .i_DP(dp_in), .i_LZ_EN(lz), .i_EN(en),
        .o_AN(an15), .o_SEG(seg15), .o_DP(dp15)
    );

    ssd_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .DISPLAY_MODE(9)) dut9 (
        .i_CLK(clk), .i_RESET(rst),
        .i_Digit_1_val(d1), .i_Digit_2_val(d2), .i_Digit_3_val(d3), .i_Digit_4_val(d4),
        .i_DP(dp_in), .i_LZ_EN(lz), .i_EN(en),
        .o_AN(an9), .o_SEG(seg9), .o_DP(dp9)
    );

    function automatic logic [6:0] tb_seg(input logic [3:0] v);
        logic [6:0] t[16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    // Predict the outputs after the coming edge, push them, then clock.
    task automatic apply();
        logic [3:0] a;
        logic [6:0] s15, s9;
        logic       p, sup;
        int         c, k;
        logic [3:0] v;
        a = 4'hF; s15 = 7'h7F; s9 = 7'h7F; p = 1'b1;
        if (rst) begin
            m_pos = 0;
            for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
            m_dp = 4'd0;
            m_lz = 1'b0;
        end else begin
            if (m_pos == 0) begin
                m_d[0] = d1; m_d[1] = d2; m_d[2] = d3; m_d[3] = d4;
                m_dp = dp_in; m_lz = lz;
            end
            c = m_pos % 8;
            k = m_pos / 8;
            if (en && c >= 2) begin
                a[k] = 1'b0;
                v    = m_d[k];
                sup  = m_lz && ((k == 3 && m_d[3] == 4'd0) ||
                                (k == 2 && m_d[3] == 4'd0 && m_d[2] == 4'd0) ||
                                (k == 1 && m_d[3] == 4'd0 && m_d[2] == 4'd0 && m_d[1] == 4'd0));
                s15  = sup ? 7'h7F : tb_seg(v);
                s9   = (sup || v > 4'd9) ? 7'h7F : tb_seg(v);
                p    = ~m_dp[k];
            end
            m_pos = (m_pos + 1) % 32;
        end
        sb.push_back({a, s15, p, a, s9, p});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; lz = 1'b0; dp_in = 4'd0;
        d4 = 4'd1; d3 = 4'd2; d2 = 4'd3; d1 = 4'd4;
        for (int e = 0; e < 2; e++) begin
            apply();
            exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
            vectors++;
            if (act_v !== exp_v) begin miscompares++; $display("FAIL reset cyc %0d: got %h want %h", e, act_v, exp_v); end
        end
        vectors++;
        if ({an15, seg15, dp15} !== {4'hF, 7'h7F, 1'b1}) begin
            miscompares++; $display("FAIL reset_out: got %h want %h", {an15, seg15, dp15}, {4'hF, 7'h7F, 1'b1});
        end
    endtask

    task automatic test_scan_basic();
        rst = 1'b0;
        for (int e = 1; e <= 64; e++) begin
            apply();
            exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
            vectors++;
            if (act_v !== exp_v) begin miscompares++; $display("FAIL scan edge %0d: got %h want %h", e, act_v, exp_v); end
            if (e <= 2 || e == 33) begin
                vectors++;
                if (an15 !== 4'hF) begin miscompares++; $display("FAIL scan_blank edge %0d: got %h want F", e, an15); end
            end
            if ((e >= 3 && e <= 8) || e == 35) begin
                vectors++;
                if ({an15, seg15} !== {4'b1110, 7'h19}) begin miscompares++; $display("FAIL scan_d1 edge %0d: got %h/%h want e/19", e, an15, seg15); end
            end
            if (e >= 11 && e <= 16) begin
                vectors++;
                if ({an15, seg15} !== {4'b1101, 7'h30}) begin miscompares++; $display("FAIL scan_d2 edge %0d: got %h/%h want d/30", e, an15, seg15); end
            end
        end
    endtask

    task automatic test_mode_hex();
        d1 = 4'hA;
        for (int e = 1; e <= 32; e++) begin
            apply();
            exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
            vectors++;
            if (act_v !== exp_v) begin miscompares++; $display("FAIL mode edge %0d: got %h want %h", e, act_v, exp_v); end
            if (e == 5) begin
                vectors++;
                if ({an9, seg9, seg15} !== {4'b1110, 7'h7F, 7'h08}) begin
                    miscompares++; $display("FAIL mode_a: got an9 %h seg9 %h seg15 %h want e 7f 08", an9, seg9, seg15);
                end
            end
        end
    endtask

    task automatic test_lz();
        lz = 1'b1; d4 = 4'd0; d3 = 4'd0; d2 = 4'd5; d1 = 4'd0;
        for (int e = 1; e <= 32; e++) begin
            apply();
            exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
            vectors++;
            if (act_v !== exp_v) begin miscompares++; $display("FAIL lz edge %0d: got %h want %h", e, act_v, exp_v); end
            if (e == 6 || e == 14 || e == 22 || e == 30) begin
                vectors++;
                if (seg15 !== ((e == 6) ? 7'h40 : (e == 14) ? 7'h12 : 7'h7F)) begin
                    miscompares++; $display("FAIL lz_seg edge %0d: got %h an %h", e, seg15, an15);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        lz = 1'b0; d4 = 4'd1; d3 = 4'd2; d2 = 4'd3; d1 = 4'd4;
        for (int e = 1; e <= 64; e++) begin
            if (e == 12) begin d1 = 4'd7; d4 = 4'd8; end
            apply();
            exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
            vectors++;
            if (act_v !== exp_v) begin miscompares++; $display("FAIL snap edge %0d: got %h want %h", e, act_v, exp_v); end
            if (e == 5 || e == 30 || e == 37 || e == 62) begin
                vectors++;
                if (seg15 !== ((e == 5) ? 7'h19 : (e == 30) ? 7'h79 : (e == 37) ? 7'h78 : 7'h00)) begin
                    miscompares++; $display("FAIL snap_seg edge %0d: got %h", e, seg15);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int e = 1; e <= 13; e++) begin
            apply();
            exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
            vectors++;
            if (act_v !== exp_v) begin miscompares++; $display("FAIL rmid pre edge %0d: got %h want %h", e, act_v, exp_v); end
        end
        rst = 1'b1;
        apply();
        exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
        vectors++;
        if (act_v !== exp_v || an15 !== 4'hF) begin miscompares++; $display("FAIL rmid reset: got %h want %h", act_v, exp_v); end
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            apply();
            exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
            vectors++;
            if (act_v !== exp_v) begin miscompares++; $display("FAIL rmid edge %0d: got %h want %h", e, act_v, exp_v); end
            if (e == 2 || e == 3) begin
                vectors++;
                if (an15 !== ((e == 2) ? 4'hF : 4'b1110)) begin miscompares++; $display("FAIL rmid_an edge %0d: got %h", e, an15); end
            end
        end
    endtask

    task automatic test_en_dp();
        dp_in = 4'b0001;
        for (int e = 1; e <= 32; e++) begin
            en = (e == 6 || e == 7) ? 1'b0 : 1'b1;
            apply();
            exp_v = sb.pop_front(); act_v = {an15, seg15, dp15, an9, seg9, dp9};
            vectors++;
            if (act_v !== exp_v) begin miscompares++; $display("FAIL endp edge %0d: got %h want %h", e, act_v, exp_v); end
            if (e == 5 || e == 6 || e == 8 || e == 13) begin
                vectors++;
                if ({an15, dp15} !== ((e == 5 || e == 8) ? {4'b1110, 1'b0} : (e == 6) ? {4'hF, 1'b1} : {4'b1101, 1'b1})) begin
                    miscompares++; $display("FAIL endp_an edge %0d: got an %h dp %b", e, an15, dp15);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_mode_hex();
        test_lz();
        test_snapshot();
        test_reset_mid();
        test_en_dp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
